// File: rtl/tlast_check_pkg.sv
// rtl/tlast_check_pkg.sv - shared FSM encoding and statistics helpers for tlast_check
package tlast_check_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

    // Increment that sticks at the all-ones value of a counter `width` bits wide (width <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/axis_stat_counter.sv
// rtl/axis_stat_counter.sv - event counter with synchronous clear, wrapping or saturating
module axis_stat_counter
    import tlast_check_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // clear has priority: an increment in the same cycle is discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (SATURATE) begin
                count <= WIDTH'(sat_inc(64'(count), WIDTH));
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tlast_check.sv
// rtl/tlast_check.sv - fixed-length AXI-Stream frame boundary checker with resync and statistics
module tlast_check
    import tlast_check_pkg::*;
#(
    parameter int C_COUNTER_WIDTH = 32,
    parameter int C_NUMBER        = 16,
    parameter int C_DATA_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       frame_ok,
    output logic                       err_early,
    output logic                       err_late,
    output logic                       err_sticky,
    output logic [C_COUNTER_WIDTH-1:0] frame_cnt,
    output logic [C_COUNTER_WIDTH-1:0] err_cnt,
    output logic [C_COUNTER_WIDTH-1:0] count_ext
);

    localparam logic [C_COUNTER_WIDTH-1:0] LAST_BEAT = C_COUNTER_WIDTH'(C_NUMBER - 1);

    state_t                     state_q, state_d;
    logic [C_COUNTER_WIDTH-1:0] count_q, count_d;
    logic                       ok_d, early_d, late_d;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        ok_d          = 1'b0;
        early_d       = 1'b0;
        late_d        = 1'b0;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        case (state_q)
            ST_RUN: begin
                if (s_axis_tvalid && m_axis_tready) begin
                    if (count_q >= LAST_BEAT) begin
                        count_d = '0;
                        if (s_axis_tlast) begin
                            ok_d = 1'b1;
                        end else begin
                            late_d  = 1'b1;
                            state_d = ST_SYNC;
                        end
                    end else if (s_axis_tlast) begin
                        early_d = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q + C_COUNTER_WIDTH'(1);
                    end
                end
            end
            ST_SYNC: begin
                // Discard everything up to and including the next tlast.
                m_axis_tvalid = 1'b0;
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_RUN;
                    count_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            frame_ok   <= 1'b0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            frame_ok  <= ok_d;
            err_early <= early_d;
            err_late  <= late_d;
            if (clear) begin
                err_sticky <= 1'b0;
            end else if (early_d || late_d) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign count_ext = count_q;

    axis_stat_counter #(
        .WIDTH    (C_COUNTER_WIDTH),
        .SATURATE (1'b0)
    ) u_frame_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .inc    (ok_d),
        .count  (frame_cnt)
    );

    axis_stat_counter #(
        .WIDTH    (C_COUNTER_WIDTH),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .inc    (early_d || late_d),
        .count  (err_cnt)
    );

endmodule

// File: tb/tb_tlast_check.sv
// tb/tb_tlast_check.sv - directed vector bench for tlast_check
module tb_tlast_check;

    localparam int CW = 32;
    localparam int N  = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          frame_ok;
    logic          err_early;
    logic          err_late;
    logic          err_sticky;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] count_ext;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlast_check #(
        .C_COUNTER_WIDTH (CW),
        .C_NUMBER        (N),
        .C_DATA_WIDTH    (DW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_ok      (frame_ok),
        .err_early     (err_early),
        .err_late      (err_late),
        .err_sticky    (err_sticky),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .count_ext     (count_ext)
    );

    // One row per clock: inputs driven after the edge, outputs expected at the following negedge.
    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          sl;
        logic          mr;
        logic          clr;
        logic          e_mv;
        logic          e_sr;
        logic          e_ok;
        logic          e_early;
        logic          e_late;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic sv, input logic [DW-1:0] sd, input logic sl, input logic mr,
                        input logic clr, input logic e_mv, input logic e_sr, input logic e_ok,
                        input logic e_early, input logic e_late);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr; v.clr = clr;
        v.e_mv = e_mv; v.e_sr = e_sr; v.e_ok = e_ok; v.e_early = e_early; v.e_late = e_late;
        vecs.push_back(v);
    endtask

    // len beats, tlast on beat tlast_at (-1 = none); pulses expected on the first row only.
    task automatic push_frame(input logic [DW-1:0] base, input int len, input int tlast_at,
                              input int clr_at, input logic ok0, input logic early0, input logic late0);
        for (int i = 0; i < len; i++) begin
            push(1'b1, base + DW'(i), (i == tlast_at), 1'b1, (i == clr_at), 1'b1, 1'b1,
                 (i == 0) ? ok0 : 1'b0, (i == 0) ? early0 : 1'b0, (i == 0) ? late0 : 1'b0);
        end
    endtask

    task automatic push_idle(input logic ok, input logic early, input logic late, input logic clr);
        push(1'b0, '0, 1'b0, 1'b1, clr, 1'b0, 1'b1, ok, early, late);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            s_axis_tvalid = vecs[i].sv;
            s_axis_tdata  = vecs[i].sd;
            s_axis_tlast  = vecs[i].sl;
            m_axis_tready = vecs[i].mr;
            clear         = vecs[i].clr;
            @(negedge clk);
            check($sformatf("row%0d_mvalid", i), m_axis_tvalid, vecs[i].e_mv);
            check($sformatf("row%0d_sready", i), s_axis_tready, vecs[i].e_sr);
            check($sformatf("row%0d_frame_ok", i), frame_ok, vecs[i].e_ok);
            check($sformatf("row%0d_err_early", i), err_early, vecs[i].e_early);
            check($sformatf("row%0d_err_late", i), err_late, vecs[i].e_late);
            if (vecs[i].e_mv) begin
                check($sformatf("row%0d_tdata", i), m_axis_tdata, vecs[i].sd);
                check($sformatf("row%0d_tlast", i), m_axis_tlast, vecs[i].sl);
            end
        end
        vecs.delete();
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        clear         = 1'b0;
    endtask

    initial begin
        int  sent;
        int  recv;
        int  cyc;
        logic pend;

        resetn        = 1'b0;
        clear         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sready_low", s_axis_tready, 1'b0);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        #1;
        check("rst_sready_high", s_axis_tready, 1'b1);
        check("rst_mvalid", m_axis_tvalid, 1'b1);
        check("rst_count", count_ext, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_pulses", {frame_ok, err_early, err_late, err_sticky}, 4'b0000);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Three good frames.
        push_frame(16'h0100, 16, 15, -1, 1'b0, 1'b0, 1'b0);
        push_frame(16'h0200, 16, 15, -1, 1'b1, 1'b0, 1'b0);
        push_frame(16'h0300, 16, 15, -1, 1'b1, 1'b0, 1'b0);
        push_idle(1'b1, 1'b0, 1'b0, 1'b0);
        push_idle(1'b0, 1'b0, 1'b0, 1'b0);
        run_vecs();
        check("good_frame_cnt", frame_cnt, 3);
        check("good_err_cnt", err_cnt, 0);
        check("good_sticky", err_sticky, 1'b0);

        // Early tlast on beat 9, then a good frame.
        push_idle(1'b0, 1'b0, 1'b0, 1'b1);
        push_frame(16'h0400, 10, 9, -1, 1'b0, 1'b0, 1'b0);
        push_frame(16'h0500, 16, 15, -1, 1'b0, 1'b1, 1'b0);
        push_idle(1'b1, 1'b0, 1'b0, 1'b0);
        run_vecs();
        check("early_frame_cnt", frame_cnt, 1);
        check("early_err_cnt", err_cnt, 1);
        check("early_sticky", err_sticky, 1'b1);

        // Missing tlast, five junk beats dropped in SYNC (even with downstream stalled), then a good frame.
        push_idle(1'b0, 1'b0, 1'b0, 1'b1);
        push_frame(16'h0600, 16, -1, -1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 16'h0700 + DW'(i), (i == 4), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (i == 0));
        end
        push_frame(16'h0800, 16, 15, -1, 1'b0, 1'b0, 1'b0);
        push_idle(1'b1, 1'b0, 1'b0, 1'b0);
        run_vecs();
        check("late_frame_cnt", frame_cnt, 1);
        check("late_err_cnt", err_cnt, 1);
        check("late_sticky", err_sticky, 1'b1);

        // 100 good frames with random source gaps and sink backpressure.
        push_idle(1'b0, 1'b0, 1'b0, 1'b1);
        run_vecs();
        sent = 0;
        recv = 0;
        cyc  = 0;
        pend = 1'b0;
        while (recv < 100 * N && cyc < 20000) begin
            @(posedge clk);
            #1;
            if (!pend && sent < 100 * N && $urandom_range(0, 3) != 0) pend = 1'b1;
            s_axis_tvalid = pend;
            s_axis_tdata  = sent[DW-1:0];
            s_axis_tlast  = ((sent % N) == N - 1);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("rand_count_range", (count_ext > 15), 1'b0);
            if (m_axis_tvalid && m_axis_tready) begin
                check("rand_tdata", m_axis_tdata, recv[DW-1:0]);
                check("rand_tlast", m_axis_tlast, ((recv % N) == N - 1));
                recv++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        check("rand_beats_received", recv, 100 * N);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        check("rand_frame_cnt", frame_cnt, 100);
        check("rand_err_cnt", err_cnt, 0);

        // Reset mid-frame after eight beats.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(i);
            s_axis_tlast  = 1'b0;
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("pre_reset_count", count_ext, 8);
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_count", count_ext, 0);
        check("async_reset_frame_cnt", frame_cnt, 0);
        check("async_reset_err_cnt", err_cnt, 0);
        check("async_reset_flags", {frame_ok, err_early, err_late, err_sticky}, 4'b0000);
        @(negedge clk);
        resetn = 1'b1;
        push_frame(16'h0900, 16, 15, -1, 1'b0, 1'b0, 1'b0);
        push_idle(1'b1, 1'b0, 1'b0, 1'b0);
        run_vecs();
        check("post_reset_frame_cnt", frame_cnt, 1);

        // Two early frames; clear lands on the edge of the second error.
        push_frame(16'h0a00, 4, 3, -1, 1'b0, 1'b0, 1'b0);
        push_frame(16'h0b00, 4, 3, 3, 1'b0, 1'b1, 1'b0);
        push_idle(1'b0, 1'b1, 1'b0, 1'b0);
        run_vecs();
        check("clear_err_cnt", err_cnt, 0);
        check("clear_sticky", err_sticky, 1'b0);
        check("clear_frame_cnt", frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlast_check.md
# tlast_check

Receive-side companion of the modulator's tlast generator. Sits on an AXI-Stream input of fixed-length frames (C_NUMBER beats, tlast on the last beat) and checks every frame boundary. Correct frames pass through unchanged. Frames whose tlast comes too early or too late are reported, and the block realigns: after a missing tlast it drops beats until the next tlast. It also provides frame and error counters for debug.

## Interface
- C_COUNTER_WIDTH, 32: width of the beat counter and of both statistics counters.
- C_NUMBER, 16: expected beats per frame, at least 1.
- C_DATA_WIDTH, 16: tdata width.

- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of statistics counters and sticky error.
- s_axis_tdata  in  C_DATA_WIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end-of-frame marker.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  C_DATA_WIDTH  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end-of-frame marker.
- m_axis_tready  in  1  output ready.
- frame_ok  out  1  one-cycle pulse for each correctly framed frame.
- err_early  out  1  one-cycle pulse: tlast arrived before beat C_NUMBER-1.
- err_late  out  1  one-cycle pulse: beat C_NUMBER-1 arrived without tlast.
- err_sticky  out  1  set by any error; cleared only by reset or clear.
- frame_cnt  out  C_COUNTER_WIDTH  count of good frames; wraps.
- err_cnt  out  C_COUNTER_WIDTH  count of errors; saturates at all-ones.
- count_ext  out  C_COUNTER_WIDTH  current beat index (debug).

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- States: RUN and SYNC. The block resets to RUN with count = 0.
- RUN: pure combinational pass-through.
  - m_axis_tvalid = s_axis_tvalid.
  - s_axis_tready = m_axis_tready.
  - tdata and tlast are wired straight through.
- RUN, accepted beat with count < C_NUMBER-1:
  - no tlast: count increments.
  - tlast: err_early pulses, count returns to 0, state stays RUN. The short frame is still forwarded.
- RUN, accepted beat with count == C_NUMBER-1:
  - tlast: frame_ok pulses, frame_cnt increments, count returns to 0.
  - no tlast: err_late pulses, count returns to 0, state goes to SYNC. The beat itself is forwarded.
- SYNC: m_axis_tvalid = 0 and s_axis_tready = 1, so every beat is dropped. When a beat with tlast is accepted, it is also dropped and the state returns to RUN with count = 0.
- Any err_early or err_late sets err_sticky and increments err_cnt; err_cnt saturates at all-ones.
- clear beats a same-cycle event: counters and err_sticky go to 0, and that cycle's counter increment is lost. The event pulse itself is still emitted.
- C_NUMBER = 1: every beat must carry tlast; a beat without tlast is an err_late.
- count is C_COUNTER_WIDTH bits wide, and C_NUMBER-1 must fit in that width.

## Timing
- Reset values:
  - state RUN, count 0.
  - frame_ok, err_early, err_late, err_sticky all 0.
  - frame_cnt and err_cnt 0.
  - m_axis_tvalid follows s_axis_tvalid. s_axis_tready follows m_axis_tready.
- Data path latency: 0 cycles (combinational) in RUN.
- frame_ok, err_early and err_late are registered. Each asserts for exactly one cycle, the cycle after the accepting edge.
- Counters and err_sticky update on the same edge as the pulse registers.
- State changes take effect on the edge that accepts the deciding beat. The beat following an err_late beat is therefore already in SYNC.
- When resetn is asserted mid-frame, all state is lost immediately and the block restarts in RUN at count 0. The next accepted beat is treated as beat 0.
- When backpressure holds m_axis_tready = 0 in RUN, nothing advances.

## Structure
- Shared package:
  - state encoding constants ST_RUN and ST_SYNC.
  - a saturating-increment function, reused by other statistics blocks in the codebase.
- One natural sub-module: axis_stat_counter, instantiated twice (wrapping for frame_cnt, saturating for err_cnt via a parameter).
- The FSM, the beat counter and the pass-through mux live in the top level.

## Test plan
- Three frames of 16 beats, tlast on beat 15, tready always 1:
  - output equals input.
  - three frame_ok pulses; frame_cnt = 3, err_cnt = 0, err_sticky = 0.
- Frame with tlast on beat 9, then a good frame:
  - err_early pulses once; err_cnt = 1, err_sticky = 1.
  - the following good frame gives frame_ok; frame_cnt = 1.
- 16 beats without tlast, then 5 junk beats with tlast on the 5th, then a good frame:
  - err_late pulses one cycle after beat 15.
  - m_axis_tvalid = 0 for all 5 junk beats.
  - the good frame passes through and frame_cnt = 1.
- Random m_axis_tready and s_axis_tvalid gaps over 100 good frames:
  - no beat is lost or duplicated.
  - frame_cnt = 100; count_ext never exceeds 15.
- resetn pulsed low at beat 7, followed by a full frame:
  - all outputs and counters return to 0 immediately.
  - the next 16-beat frame gives frame_ok.
- clear asserted on the same cycle an err_early is registered:
  - err_cnt = 0 and err_sticky = 0 afterwards.
  - the err_early pulse is still seen.
